// File: rtl/tage_hist_fold.sv
// Global/path history and folded-history registers for the TAGE predictor core.
// Optional path history is built when TAGE_PATH_HIST_EN is defined; otherwise phist is tied to zero.
module tage_hist_fold (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    input  logic              upd_taken,
    input  logic [31:0]       upd_pc,
    input  logic              flush,
    output logic [11:0][31:0] ch_i,
    output logic [11:0][31:0] ch_t0,
    output logic [11:0][31:0] ch_t1,
    output logic [15:0]       phist,
    output logic              hist_full
);

    localparam int NUM_TABLES = 12;
    localparam int GHIST_LEN  = 640;

    function automatic int hlen(input int k);
        case (k)
            0: return 4;     1: return 6;     2: return 10;    3: return 16;
            4: return 25;    5: return 40;    6: return 64;    7: return 101;
            8: return 160;   9: return 254;   10: return 403;  default: return 640;
        endcase
    endfunction

    function automatic int idx_w(input int k);
        case (k)
            0, 1, 6, 7, 8, 9: return 10;
            2, 3, 4, 5:       return 11;
            default:          return 9;
        endcase
    endfunction

    function automatic int tag_w(input int k);
        case (k)
            0, 1:   return 7;
            2, 3:   return 8;
            4:      return 9;
            5:      return 10;
            6:      return 11;
            7, 8:   return 12;
            9:      return 13;
            10:     return 14;
            default: return 15;
        endcase
    endfunction

    // One-cycle fold update: shift in the new outcome, cancel the bit leaving the
    // L-bit window, and wrap the carry-out of bit W back onto bit 0.
    function automatic logic [31:0] fold_step(input logic [31:0] f, input logic in_bit,
                                              input logic out_bit, input int w, input int l);
        logic [32:0] t;
        t = {f, in_bit};
        t = t ^ ({32'd0, out_bit} << (l % w));
        t = t ^ ((t >> w) & 33'd1);
        t = t & ((33'd1 << w) - 33'd1);
        return t[31:0];
    endfunction

    logic [GHIST_LEN-1:0] ghist_q, ghist_d;
    logic [9:0]           hist_count_q, hist_count_d;
    logic                 hist_full_q, hist_full_d;

    always_comb begin
        ghist_d      = ghist_q;
        hist_count_d = hist_count_q;
        if (flush) begin
            ghist_d      = '0;
            hist_count_d = '0;
        end else if (upd_valid) begin
            ghist_d = {ghist_q[GHIST_LEN-2:0], upd_taken};
            if (hist_count_q != 10'(GHIST_LEN))
                hist_count_d = hist_count_q + 10'd1;
        end
        hist_full_d = (hist_count_d == 10'(GHIST_LEN));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ghist_q      <= '0;
            hist_count_q <= '0;
            hist_full_q  <= 1'b0;
        end else begin
            ghist_q      <= ghist_d;
            hist_count_q <= hist_count_d;
            hist_full_q  <= hist_full_d;
        end
    end

    assign hist_full = hist_full_q;

    for (genvar k = 0; k < NUM_TABLES; k++) begin : g_slot
        localparam int L   = hlen(k);
        localparam int WI  = idx_w(k);
        localparam int WT0 = tag_w(k);
        localparam int WT1 = tag_w(k) - 1;

        logic [31:0] ci_q, ci_d;
        logic [31:0] ct0_q, ct0_d;
        logic [31:0] ct1_q, ct1_d;
        logic        old_bit;

        assign old_bit = ghist_q[L-1];

        always_comb begin
            ci_d  = ci_q;
            ct0_d = ct0_q;
            ct1_d = ct1_q;
            if (flush) begin
                ci_d  = '0;
                ct0_d = '0;
                ct1_d = '0;
            end else if (upd_valid) begin
                ci_d  = fold_step(ci_q,  upd_taken, old_bit, WI,  L);
                ct0_d = fold_step(ct0_q, upd_taken, old_bit, WT0, L);
                ct1_d = fold_step(ct1_q, upd_taken, old_bit, WT1, L);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                ci_q  <= '0;
                ct0_q <= '0;
                ct1_q <= '0;
            end else begin
                ci_q  <= ci_d;
                ct0_q <= ct0_d;
                ct1_q <= ct1_d;
            end
        end

        assign ch_i[k]  = ci_q;
        assign ch_t0[k] = ct0_q;
        assign ch_t1[k] = ct1_q;
    end

`ifdef TAGE_PATH_HIST_EN
    logic [15:0] phist_q, phist_d;
    logic        unused_pc;

    assign unused_pc = ^{upd_pc[31:3], upd_pc[1:0]};

    always_comb begin
        phist_d = phist_q;
        if (flush)
            phist_d = '0;
        else if (upd_valid)
            phist_d = {phist_q[14:0], upd_pc[2]};
    end

    always_ff @(posedge clk) begin
        if (!reset)
            phist_q <= '0;
        else
            phist_q <= phist_d;
    end

    assign phist = phist_q;
`else
    logic unused_pc;

    assign unused_pc = ^upd_pc;
    assign phist     = 16'h0;
`endif

endmodule

// File: doc/tage_hist_fold.md
# tage_hist_fold

Global-history and folded-history maintenance unit feeding the TAGE predictor core. Keeps the 640-bit global branch history and a 16-bit path history. On every resolved branch it updates, in one cycle, the 36 compressed (folded) history registers the core consumes: per table one index fold, ch_i, and two tag folds, ch_t0 and ch_t1. All outputs are registered and drive the predictor's hash inputs directly.

## Interface
- NUM_TABLES, 12, tagged tables T1..T12, mapped to output slots 0..11
- GHIST_LEN, 640, global history depth in bits
- PHIST_LEN, 16, path history depth in bits
- HLEN[k], 4,6,10,16,25,40,64,101,160,254,403,640, history length folded for slot k
- IDX_W[k], 10,10,11,11,11,11,10,10,10,10,9,9, ch_i fold width for slot k
- TAG_W[k], 7,7,8,8,9,10,11,12,12,13,14,15, ch_t0 fold width; ch_t1 width is TAG_W[k]-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- upd_valid  in  1  resolved branch this cycle
- upd_taken  in  1  outcome of the resolved branch
- upd_pc  in  32  PC of the resolved branch
- flush  in  1  clear all history (context switch)
- ch_i  out  32 x [11:0]  index folds, zero-extended above IDX_W[k]
- ch_t0  out  32 x [11:0]  tag fold 0, zero-extended
- ch_t1  out  32 x [11:0]  tag fold 1, zero-extended
- phist  out  16  path history
- hist_full  out  1  GHIST_LEN updates have occurred since reset or flush

## Operation
- Global history is a shift register, ghist[0] = newest bit. On an update: ghist <= {ghist[638:0], upd_taken}.
- Each fold register F, of width W and length L, updates on the same edge as the shift, using the pre-update history:
  - t = (F << 1) | upd_taken
  - t ^= ghist[L-1] << (L mod W)
  - t ^= t >> W
  - F <= t & ((1<<W)-1)
- Invariant: F always equals the XOR-fold of ghist[L-1:0] into W bits, where bit i goes to position i mod W. A bench model may recompute the fold from scratch and compare.
- Path history, macro-dependent (see Configuration).
- hist_count is a 10-bit saturating counter, incremented per update and saturating at GHIST_LEN. hist_full = (hist_count == GHIST_LEN).
- flush = 1: ghist, all folds, phist and hist_count clear to 0 on the next edge. flush overrides a simultaneous upd_valid; that update is discarded.
- upd_valid = 0 and flush = 0: all state holds.

## Timing
- Reset: every output is 0, ghist is 0, hist_count is 0.
- Reset asserted mid-operation clears state on the next edge and overrides flush and upd_valid.
- Latency 1: an update sampled at edge N is visible on all outputs after edge N. Back-to-back updates are accepted every cycle with no stall; there is no ready signal.
- Outputs change only on clock edges with upd_valid, flush or reset active. No combinational path from input to output.
- Fold arithmetic is done at W+1 bits. Bits above W in the 32-bit outputs are always 0.

## Configuration
- TAGE_PATH_HIST_EN defined:
  - on update, phist <= {phist[14:0], upd_pc[2]}
  - phist cleared by reset and flush
- TAGE_PATH_HIST_EN undefined:
  - path register not built
  - phist tied to 16'h0
  - all other behaviour identical

## Test plan
- Reset low for 2 cycles, then release with no updates: all ch_i/ch_t0/ch_t1 = 0, phist = 0, hist_full = 0.
- 1 taken update: next cycle every ch_i[k], ch_t0[k], ch_t1[k] = 1.
- 5 consecutive taken updates: ch_i[0] = 4'hF (L=4 window, oldest bit cancelled at position 4), ch_i[1] = 5'h1F.
- 10 consecutive taken updates: ch_i[11] = 9'h1FE (bit 9 wraps onto bit 0), ch_t0[11] = 10'h3FF.
- Random taken stream of 700 updates, checked every cycle against a from-scratch fold model:
  - all 36 folds match
  - hist_full rises exactly after the 640th update
- flush and upd_valid = 1 in the same cycle after 20 updates:
  - all outputs = 0 next cycle
  - hist_full = 0
  - with the macro defined, phist = 0; with it undefined, phist stays 0 throughout.
